// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cla_pkg
// Purpose : Shared constants and types for the nibble-serial adder:
//           FSM state encoding and the datapath slice width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Width of one serial step; also the width of the CLA slice.
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
// Module  : cla_adder
// Purpose : 4-bit carry-look-ahead adder, purely combinational.
// Ports   : a[3:0], b[3:0] - addends
//           cin            - carry in
//           sum[3:0]       - a + b + cin, low 4 bits
//           cout           - carry out of bit 3
// Revision: 1.0 - initial release
// ============================================================================
module cla_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is expanded directly from cin so no carry depends on
    // another carry output.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum  = w_p ^ w_c[3:0];
    assign cout = w_c[4];

endmodule : cla_adder
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_adder
// Purpose : WIDTH-bit adder that processes one 4-bit nibble per clock,
//           LSB nibble first, through a single CLA slice. Operands are
//           captured on accept; the result is held until the consumer
//           takes it.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           a, b, cin         - operands, sampled when in_valid & in_ready
//           in_valid/in_ready - input handshake
//           sum, cout, ovf    - registered result, carry out, signed overflow
//           out_valid/out_ready - output handshake
// Revision: 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIBS);

    if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic [IDX_W-1:0]  r_idx;

    logic              w_accept;
    logic              w_last;
    logic [NIB_W-1:0]  w_nib_a;
    logic [NIB_W-1:0]  w_nib_b;
    logic [NIB_W-1:0]  w_nib_sum;
    logic              w_nib_cout;

    // Operand nibbles come only from the captured registers, so the live
    // a/b/cin inputs never reach an output combinationally.
    assign w_nib_a  = r_a[r_idx*NIB_W +: NIB_W];
    assign w_nib_b  = r_b[r_idx*NIB_W +: NIB_W];
    assign w_last   = (r_idx == IDX_W'(NIBS - 1));
    assign w_accept = in_valid && (r_state == IDLE);

    cla_adder u_cla (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture and one nibble per CALC cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            // r_carry doubles as the carry-in of nibble 0.
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (r_state == CALC) begin
            r_sum[r_idx*NIB_W +: NIB_W] <= w_nib_sum;
            r_carry                     <= w_nib_cout;
            r_idx                       <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_nib_cout;
                // Carry into the MSB is recovered from the MSB sum bit.
                r_ovf  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_nib_sum[NIB_W-1])
                          ^ w_nib_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_serial_adder
// Purpose : Self-checking bench for nibble_serial_adder (WIDTH=16).
//           Driver issues operations and queues expected results; a monitor
//           compares each result as it is handed over.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [17:0] sb_q[$];   // {ovf, cout, sum}
    int          acc_q[$];  // cycle of each accept edge
    logic        seen;
    logic        rand_rdy;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #800000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%0h req=%0h", name, act, req);
        end
    endtask

    // Reference: signed overflow from operand/result sign bits.
    function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t[W], t[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one operation, queues its expected result.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic [17:0] exp);
        int guard;
        guard = 0;
        while (!in_ready && guard < 300) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sb_q.push_back(exp);
        acc_q.push_back(cyc);
    endtask

    // Monitor: latency on first sight of out_valid, data on handshake.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst) begin
            seen <= 1'b0;
        end else begin
            if (out_valid && !seen) begin
                seen <= 1'b1;
                if (acc_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    chk("latency", 32'(cyc - acc_q.pop_front()), 32'd4);
                end
            end
            if (out_valid && out_ready) begin
                seen <= 1'b0;
                if (sb_q.size() == 0) begin
                    chk("spurious_result", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sum",  32'(sum),  32'(e[15:0]));
                    chk("cout", 32'(cout), 32'(e[16]));
                    chk("ovf",  32'(ovf),  32'(e[17]));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 300) begin
            step();
            guard++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;
        int           guard;

        rst       = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rand_rdy  = 1'b0;
        seen      = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);

        // Directed vectors, expected {ovf, cout, sum} computed by hand
        issue(16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002});
        issue(16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
        issue(16'hFFFF, 16'hFFFF, 1'b1, {1'b0, 1'b1, 16'hFFFF});
        issue(16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
        issue(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});
        issue(16'h8000, 16'hFFFF, 1'b0, {1'b1, 1'b1, 16'h7FFF});
        drain();

        // Backpressure: junk on inputs during CALC/DONE must be ignored
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555});
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        in_valid = 1'b1;
        guard = 0;
        while (!out_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("stall_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_sum",   32'(sum),       32'h5555);
            chk("stall_in_ready",   32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("release_in_ready",  32'(in_ready),  32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("idle_holds_sum",    32'(sum),       32'h5555);
        drain();

        // Reset during the second CALC cycle aborts the operation
        issue(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        acc_q.delete();
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum",       32'(sum),       32'd0);
        chk("abort_cout",      32'(cout),      32'd0);
        // Accepted on the first edge after reset release; its latency check
        // also confirms no stale valid from the aborted operation.
        issue(16'h00A5, 16'h005A, 1'b1, {1'b0, 1'b0, 16'h0100});
        drain();

        // Random operands with random consumer stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            issue(rx, ry, rc, model(rx, ry, rc));
        end
        drain();
        rand_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nibble_serial_adder
`default_nettype wire
